// File: rtl/demux8_stream_sched.sv
// demux8_stream_sched: steers a valid/ready stream onto 8 channels, round-robin bursts or addressed
module demux8_stream_sched #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic [7:0]   chan_en,
  input  logic [2:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [W-1:0] out_data,
  output logic [2:0]   cur_sel,
  output logic         busy,
  output logic [7:0]   err_cnt
);
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [2:0] ptr, rr_tgt, tgt;
  logic [CW-1:0] beat_cnt;
  logic hold_mode;
  // accept readiness and target: lowest circular offset from ptr among enabled channels
  always_comb begin
    in_ready = state == IDLE && (mode || |chan_en);
    rr_tgt = ptr;
    for (int i = 7; i >= 0; i--)
      if (chan_en[ptr + 3'(i)]) rr_tgt = ptr + 3'(i);
    tgt = mode ? in_sel : rr_tgt;
  end
  assign busy = state == HOLD;
  // single-beat holding FSM; the round-robin update follows the mode the beat was accepted in
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= '0;
      out_data  <= '0;
      cur_sel   <= '0;
      err_cnt   <= '0;
      ptr       <= '0;
      beat_cnt  <= '0;
      hold_mode <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid && in_ready) begin
        if (chan_en[tgt]) begin
          out_data  <= in_data;
          out_valid <= 8'b1 << tgt;
          cur_sel   <= tgt;
          hold_mode <= mode;
          state     <= HOLD;
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end else if (out_ready[cur_sel]) begin
      out_valid <= '0;
      state     <= IDLE;
      if (hold_mode) begin
        beat_cnt <= '0;
      end else if (beat_cnt == LAST) begin
        beat_cnt <= '0;
        ptr      <= cur_sel + 3'd1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        ptr      <= cur_sel;
      end
    end
  end
endmodule
